// File: rtl/systolic_array_ctrl_if.sv
// Bundle of the systolic array sequencer's command, tile-buffer and array
// control signals.
//   slave  : the sequencer side (systolic_array_ctrl)
//   master : the surrounding core / tile buffer / array side
// Ports carried:
//   start, k_len, use_weights      command issue
//   busy, done, last_cycles        command status
//   op_rd_en, op_sel, op_rd_idx    tile-buffer read request
//   op_a_flat, op_b_flat           tile-buffer read data (one cycle later)
//   arr_enable, clear_acc,
//   load_weights, compute_enable   array control strobes
//   a_inputs_flat, b_inputs_flat   skewed operand buses to the array
//   arr_ready                      array ready/status
interface systolic_array_ctrl_if #(
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned K_BITS     = 8
);
    localparam int unsigned FLAT_BITS = ARRAY_SIZE * DATA_BITS;

    logic                 start;
    logic [K_BITS-1:0]    k_len;
    logic                 use_weights;
    logic                 busy;
    logic                 done;
    logic [15:0]          last_cycles;

    logic                 op_rd_en;
    logic                 op_sel;
    logic [K_BITS-1:0]    op_rd_idx;
    logic [FLAT_BITS-1:0] op_a_flat;
    logic [FLAT_BITS-1:0] op_b_flat;

    logic                 arr_enable;
    logic                 clear_acc;
    logic                 load_weights;
    logic                 compute_enable;
    logic [FLAT_BITS-1:0] a_inputs_flat;
    logic [FLAT_BITS-1:0] b_inputs_flat;
    logic                 arr_ready;

    modport slave (
        input  start, k_len, use_weights,
        output busy, done, last_cycles,
        output op_rd_en, op_sel, op_rd_idx,
        input  op_a_flat, op_b_flat,
        output arr_enable, clear_acc, load_weights, compute_enable,
        output a_inputs_flat, b_inputs_flat,
        input  arr_ready
    );

    modport master (
        output start, k_len, use_weights,
        input  busy, done, last_cycles,
        input  op_rd_en, op_sel, op_rd_idx,
        output op_a_flat, op_b_flat,
        input  arr_enable, clear_acc, load_weights, compute_enable,
        input  a_inputs_flat, b_inputs_flat,
        output arr_ready
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for an ARRAY_SIZE x ARRAY_SIZE Q1.15 systolic array. Accepts one
// matmul command at a time, clears the accumulators, optionally streams a
// weight tile into the array, then fetches K operand rows from the tile buffer
// and skews them lane by lane onto the array's A/B buses while holding
// compute_enable, waits for the array to report ready and pulses done.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    systolic_array_ctrl_if.slave (command, tile-buffer, array control)
module systolic_array_ctrl #(
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned K_BITS     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    systolic_array_ctrl_if.slave  bus
);

    localparam int unsigned FLAT_BITS = ARRAY_SIZE * DATA_BITS;
    // Wide enough for K + 2*(N-1), the last FEED cycle index.
    localparam int unsigned CNT_BITS  = K_BITS + $clog2(2 * ARRAY_SIZE) + 1;
    localparam int unsigned CYC_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_W,
        FEED,
        WAIT_RDY,
        DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [CNT_BITS-1:0]   cnt;
    logic [CNT_BITS-1:0]   cnt_n;

    logic [K_BITS-1:0]     k_q;
    logic                  use_w_q;
    logic [CNT_BITS-1:0]   k_ext;
    logic [CNT_BITS-1:0]   load_last;
    logic [CNT_BITS-1:0]   feed_last;

    // Registered control outputs and their next-cycle values.
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_en_q;
    logic                  sel_q;
    logic [K_BITS-1:0]     idx_q;
    logic                  clear_q;
    logic                  load_q;
    logic                  ce_q;
    logic                  busy_n;
    logic                  done_n;
    logic                  rd_en_n;
    logic                  sel_n;
    logic [K_BITS-1:0]     idx_n;
    logic                  clear_n;
    logic                  load_n;
    logic                  ce_n;

    logic [CYC_BITS-1:0]   busy_cnt;
    logic [CYC_BITS-1:0]   last_q;

    // vld[i]: the operand row now on lane i's pipe output is a real FEED row.
    logic [ARRAY_SIZE-1:0] vld;
    logic [FLAT_BITS-1:0]  skew_a;
    logic [FLAT_BITS-1:0]  skew_b;

    assign k_ext     = CNT_BITS'(k_q);
    assign load_last = CNT_BITS'(ARRAY_SIZE);
    assign feed_last = k_ext + CNT_BITS'(2 * ARRAY_SIZE - 2);

    // Next state, phase counter and the control outputs for the next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        rd_en_n = 1'b0;
        sel_n   = 1'b0;
        idx_n   = '0;
        clear_n = 1'b0;
        load_n  = 1'b0;
        ce_n    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && bus.arr_ready) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            CLEAR: begin
                cnt_n = '0;
                if (use_w_q) begin
                    state_n = LOAD_W;
                end else if (k_q != '0) begin
                    state_n = FEED;
                end else begin
                    state_n = WAIT_RDY;
                end
            end
            LOAD_W: begin
                if (cnt == load_last) begin
                    cnt_n   = '0;
                    state_n = (k_q != '0) ? FEED : WAIT_RDY;
                end else begin
                    cnt_n = cnt + CNT_BITS'(1);
                end
            end
            FEED: begin
                if (cnt == feed_last) begin
                    cnt_n   = '0;
                    state_n = WAIT_RDY;
                end else begin
                    cnt_n = cnt + CNT_BITS'(1);
                end
            end
            WAIT_RDY: begin
                if (bus.arr_ready) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they can be registered.
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        clear_n = (state_n == CLEAR);
        case (state_n)
            LOAD_W: begin
                // Reads on counts 0..N-1, their data lands on counts 1..N.
                rd_en_n = (cnt_n < load_last);
                sel_n   = rd_en_n;
                load_n  = (cnt_n != '0);
            end
            FEED: begin
                // Reads on counts 0..K-1; compute starts when row 0 returns.
                rd_en_n = (cnt_n < k_ext);
                ce_n    = (cnt_n != '0);
            end
            default: begin
            end
        endcase
        if (rd_en_n) begin
            idx_n = K_BITS'(cnt_n);
        end
    end

    // State, command capture, registered outputs and busy-cycle accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            k_q      <= '0;
            use_w_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            sel_q    <= 1'b0;
            idx_q    <= '0;
            clear_q  <= 1'b0;
            load_q   <= 1'b0;
            ce_q     <= 1'b0;
            busy_cnt <= '0;
            last_q   <= '0;
            vld      <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            rd_en_q <= rd_en_n;
            sel_q   <= sel_n;
            idx_q   <= idx_n;
            clear_q <= clear_n;
            load_q  <= load_n;
            ce_q    <= ce_n;

            if (state == IDLE && state_n == CLEAR) begin
                k_q     <= bus.k_len;
                use_w_q <= bus.use_weights;
            end

            // busy_cnt equals the number of busy cycles so far, including the
            // current one; it saturates rather than wrapping on long stalls.
            if (state_n == CLEAR) begin
                busy_cnt <= CYC_BITS'(1);
            end else if (busy_n && busy_cnt != '1) begin
                busy_cnt <= busy_cnt + CYC_BITS'(1);
            end

            if (state_n == DONE) begin
                last_q <= (busy_cnt == '1) ? busy_cnt : busy_cnt + CYC_BITS'(1);
            end

            // Operand data is valid the cycle after a FEED read; lane i sees
            // that valid bit i cycles later.
            vld <= {vld[ARRAY_SIZE-2:0], rd_en_q & ~sel_q};
        end
    end

    // Per-lane skew: lane i delays the returned row by i cycles.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic [DATA_BITS-1:0] a_in;
        logic [DATA_BITS-1:0] b_in;
        logic [DATA_BITS-1:0] a_dly;
        logic [DATA_BITS-1:0] b_dly;

        assign a_in = bus.op_a_flat[i*DATA_BITS +: DATA_BITS];
        assign b_in = bus.op_b_flat[i*DATA_BITS +: DATA_BITS];

        if (i == 0) begin : g_direct
            assign a_dly = a_in;
            assign b_dly = b_in;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] a_pipe [i];
            logic [DATA_BITS-1:0] b_pipe [i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < i; k++) begin
                        a_pipe[k] <= '0;
                        b_pipe[k] <= '0;
                    end
                end else begin
                    a_pipe[0] <= a_in;
                    b_pipe[0] <= b_in;
                    for (int k = 1; k < i; k++) begin
                        a_pipe[k] <= a_pipe[k-1];
                        b_pipe[k] <= b_pipe[k-1];
                    end
                end
            end

            assign a_dly = a_pipe[i-1];
            assign b_dly = b_pipe[i-1];
        end

        assign skew_a[i*DATA_BITS +: DATA_BITS] = vld[i] ? a_dly : '0;
        assign skew_b[i*DATA_BITS +: DATA_BITS] = vld[i] ? b_dly : '0;
    end

    // Weight rows go straight through; A is held at zero while they load.
    assign bus.a_inputs_flat  = load_q ? '0 : skew_a;
    assign bus.b_inputs_flat  = load_q ? bus.op_b_flat : skew_b;

    assign bus.busy           = busy_q;
    assign bus.arr_enable     = busy_q;
    assign bus.done           = done_q;
    assign bus.last_cycles    = last_q;
    assign bus.op_rd_en       = rd_en_q;
    assign bus.op_sel         = sel_q;
    assign bus.op_rd_idx      = idx_q;
    assign bus.clear_acc      = clear_q;
    assign bus.load_weights   = load_q;
    assign bus.compute_enable = ce_q;

    // The array must never see two phase strobes at once.
    strobe_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({clear_q, load_q, ce_q}));

endmodule
